fetch_stage: RTL and testbench

Instruction-fetch stage of the 32-bit pipelined MIPS core, directly upstream of the instruction memory and feeding the decode stage. It owns the program counter and drives the word address into instruction memory, which returns the instruction combinationally. It latches the returned instruction into the IF/ID pipeline register. It handles stalls from the hazard unit and branch/jump redirects from later stages, and flushes the wrong-path instruction.

---
 rtl/core_pkg.sv | 28 ++
 rtl/if_id_reg.sv | 25 ++
 rtl/fetch_stage.sv | 108 ++++++++++
 tb/tb_fetch_stage.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the pipelined MIPS core: defaults, NOP encoding
// and the IF/ID pipeline register payload.
package core_pkg;

    localparam int unsigned CORE_ADDR_W        = 32;
    localparam int unsigned IMEM_DEPTH_DEFAULT = 1024;
    localparam int unsigned RESET_PC_DEFAULT   = 0;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]            instr;
        logic [CORE_ADDR_W-1:0] pc1;
        logic                   valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        instr: NOP_INSTR,
        pc1:   '0,
        valid: 1'b0
    };

    typedef enum logic {
        FETCH_ST   = 1'b0,
        RECOVER_ST = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register holding an if_id_t payload.
// Flush has priority over load; reset and flush both produce a bubble.
module if_id_reg
    import core_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    // Payload register: flush > load > hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= IF_ID_BUBBLE;
        end else if (flush) begin
            q <= IF_ID_BUBBLE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory,
// latches the returned word into IF/ID, and handles stall and redirect.
module fetch_stage
    import core_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
    parameter int unsigned RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc1,
    output logic              if_id_valid,
    output logic [31:0]       fetch_count
);

    localparam logic [ADDR_W-1:0] PC_MASK  = ADDR_W'(IMEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC) & PC_MASK;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_seq;
    logic [ADDR_W-1:0] redirect_target;
    logic              count_inc;
    logic              load;
    logic              flush;
    fetch_state_t      state;
    fetch_state_t      state_next;
    if_id_t            if_id_d;
    if_id_t            if_id_q;

    assign imem_addr = pc;

    // Fetch control: redirect beats stall; otherwise advance sequentially.
    always_comb begin
        pc_seq          = (pc + ADDR_W'(1)) & PC_MASK;
        redirect_target = redirect_pc & PC_MASK;
        pc_d            = pc;
        load            = 1'b0;
        flush           = 1'b0;
        count_inc       = 1'b0;
        state_next      = state;
        if (redirect) begin
            pc_d       = redirect_target;
            flush      = 1'b1;
            state_next = RECOVER_ST;
        end else if (!stall) begin
            pc_d       = pc_seq;
            load       = 1'b1;
            count_inc  = 1'b1;
            state_next = FETCH_ST;
        end
    end

    // Control state: RECOVER_ST marks that IF/ID currently holds the redirect bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH_ST;
        end else begin
            state <= state_next;
        end
    end

    // Program counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= PC_RESET;
        end else begin
            pc <= pc_d;
        end
    end

    // Count of real instructions delivered to decode; bubbles are not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= '0;
        end else if (count_inc) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    // The payload carries a fixed-width pc1 field; resize to/from ADDR_W.
    assign if_id_d = '{
        instr: imem_instr,
        pc1:   CORE_ADDR_W'(pc_seq),
        valid: 1'b1
    };

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .flush (flush),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign if_id_instr = if_id_q.instr;
    assign if_id_pc1   = ADDR_W'(if_id_q.pc1);
    assign if_id_valid = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a combinational
// instruction memory model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc1;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    logic [31:0] mem [1024];

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr[9:0]];

    fetch_stage #(
        .ADDR_W     (32),
        .IMEM_DEPTH (1024),
        .RESET_PC   (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_instr (if_id_instr),
        .if_id_pc1   (if_id_pc1),
        .if_id_valid (if_id_valid),
        .fetch_count (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full snapshot of stage outputs.
    task automatic expect_all(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                              input logic [31:0] pc1, input logic valid, input logic [31:0] cnt);
        check({tag, ".addr"},  imem_addr, addr);
        check({tag, ".instr"}, if_id_instr, instr);
        check({tag, ".pc1"},   if_id_pc1, pc1);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
        check({tag, ".count"}, fetch_count, cnt);
    endtask

    // One rising edge, then settle 1 time unit before sampling/driving.
    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[0] = 32'h0294_5020;

        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        repeat (3) edge1();
        rst = 1'b0;
        #1;
        expect_all("reset", 32'd0, 32'h0, 32'd0, 1'b0, 32'd0);

        // straight line
        edge1(); expect_all("seq0", 32'd1, 32'h0294_5020, 32'd1, 1'b1, 32'd1);
        edge1(); expect_all("seq1", 32'd2, 32'h1000_0001, 32'd2, 1'b1, 32'd2);
        edge1(); expect_all("seq2", 32'd3, 32'h1000_0002, 32'd3, 1'b1, 32'd3);
        edge1(); expect_all("seq3", 32'd4, 32'h1000_0003, 32'd4, 1'b1, 32'd4);

        // branch redirect to 5
        redirect = 1'b1; redirect_pc = 32'd5;
        edge1(); expect_all("br_bubble", 32'd5, 32'h0, 32'd0, 1'b0, 32'd4);
        redirect = 1'b0;
        edge1(); expect_all("br_target", 32'd6, 32'h1000_0005, 32'd6, 1'b1, 32'd5);

        // move to pc=2 with word 1 in IF/ID, then stall
        redirect = 1'b1; redirect_pc = 32'd1;
        edge1(); expect_all("to1", 32'd1, 32'h0, 32'd0, 1'b0, 32'd5);
        redirect = 1'b0;
        edge1(); expect_all("fetch1", 32'd2, 32'h1000_0001, 32'd2, 1'b1, 32'd6);
        stall = 1'b1;
        edge1(); expect_all("stall_a", 32'd2, 32'h1000_0001, 32'd2, 1'b1, 32'd6);
        edge1(); expect_all("stall_b", 32'd2, 32'h1000_0001, 32'd2, 1'b1, 32'd6);
        edge1(); expect_all("stall_c", 32'd2, 32'h1000_0001, 32'd2, 1'b1, 32'd6);
        stall = 1'b0;
        edge1(); expect_all("unstall", 32'd3, 32'h1000_0002, 32'd3, 1'b1, 32'd7);

        // redirect to the current pc still flushes and refetches
        redirect = 1'b1; redirect_pc = 32'd3;
        edge1(); expect_all("self_bubble", 32'd3, 32'h0, 32'd0, 1'b0, 32'd7);
        redirect = 1'b0;
        edge1(); expect_all("self_refetch", 32'd4, 32'h1000_0003, 32'd4, 1'b1, 32'd8);

        // redirect together with stall: redirect wins, 0x400 masks to 0
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h400;
        edge1(); expect_all("rd_stall", 32'd0, 32'h0, 32'd0, 1'b0, 32'd8);

        // back-to-back redirects, second target masks 0x7FF -> 1023
        stall = 1'b0; redirect_pc = 32'd1023;
        edge1(); expect_all("b2b_a", 32'd1023, 32'h0, 32'd0, 1'b0, 32'd8);
        redirect_pc = 32'h7FF;
        edge1(); expect_all("b2b_b", 32'd1023, 32'h0, 32'd0, 1'b0, 32'd8);
        redirect = 1'b0;

        // wrap from 1023
        edge1(); expect_all("wrap", 32'd0, 32'h1000_03FF, 32'd0, 1'b1, 32'd9);
        edge1(); expect_all("after_wrap", 32'd1, 32'h0294_5020, 32'd1, 1'b1, 32'd10);

        // redirect to pc+1 still bubbles
        redirect = 1'b1; redirect_pc = 32'd2;
        edge1(); expect_all("pc1_bubble", 32'd2, 32'h0, 32'd0, 1'b0, 32'd10);
        redirect = 1'b0;
        edge1(); expect_all("pc1_fetch", 32'd3, 32'h1000_0002, 32'd3, 1'b1, 32'd11);

        // mid-run async reset between edges, with pending stall/redirect
        #2;
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'd7;
        rst = 1'b1;
        #1;
        expect_all("async_rst", 32'd0, 32'h0, 32'd0, 1'b0, 32'd0);
        edge1();
        stall = 1'b0; redirect = 1'b0;
        #1;
        rst = 1'b0;
        edge1(); expect_all("post_rst", 32'd1, 32'h0294_5020, 32'd1, 1'b1, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
